// File: rtl/bridge_pkg.sv
// Shared constants for the UART bridge FIFOs.
package bridge_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned FIFO_AFULL = 12;

endpackage : bridge_pkg

// File: rtl/bridge_fifo_ram.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset.
module bridge_fifo_ram
    import bridge_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port: store the byte on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port: combinational lookup so the head byte is visible immediately.
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule : bridge_fifo_ram

// File: rtl/bridge_fifo.sv
// Show-ahead byte FIFO with level, threshold flags and sticky error flags.
module bridge_fifo
    import bridge_pkg::*;
#(
    parameter int unsigned DEPTH     = FIFO_DEPTH,
    parameter int unsigned AFULL_LVL = FIFO_AFULL,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned LW       = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              we,
    output logic              full,
    output logic              almost_full,
    output logic [DATA_W-1:0] rd_data,
    input  logic              re,
    output logic              not_empty,
    output logic [LW-1:0]     level,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              rd_acc;
    logic              wr_acc;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    // Status flags decode from the registered level only.
    always_comb begin
        not_empty   = (level_q != LW'(0));
        full        = (level_q == LW'(DEPTH));
        almost_full = (level_q >= LW'(AFULL_LVL));
        level       = level_q;
        overflow    = overflow_q;
        underflow   = underflow_q;
        rd_data     = not_empty ? ram_rdata : DATA_W'(0);
    end

    // Accept decisions and next-state for pointers, level and sticky flags.
    always_comb begin
        rd_acc      = re & not_empty;
        // A same-cycle pop frees a slot, so a write while full is still taken.
        wr_acc      = we & (~full | rd_acc);
        ram_we      = wr_acc & ~reset;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // A new error in the same cycle as clr_err wins over the clear.
        overflow_d  = (overflow_q & ~clr_err) | (we & ~wr_acc);
        underflow_d = (underflow_q & ~clr_err) | (re & ~not_empty);
    end

    // State registers with synchronous reset; storage is not reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= AW'(0);
            rd_ptr_q    <= AW'(0);
            level_q     <= LW'(0);
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    bridge_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

endmodule : bridge_fifo

// File: tb/tb_bridge_fifo.sv
// Directed bench for bridge_fifo: vector table plus multi-cycle corner sequences.
module tb_bridge_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] wr_data;
    logic       we;
    logic       full;
    logic       almost_full;
    logic [7:0] rd_data;
    logic       re;
    logic       not_empty;
    logic [4:0] level;
    logic       overflow;
    logic       underflow;
    logic       clr_err;

    int checks;
    int failures;

    typedef struct {
        logic       we;
        logic       re;
        logic       clr;
        logic [7:0] wdata;
        int         exp_level;
        int         exp_rd;
        int         exp_ne;
        int         exp_ovf;
        int         exp_unf;
    } vec_t;

    vec_t vecs [7];

    bridge_fifo #(
        .DEPTH     (16),
        .AFULL_LVL (12)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_data     (wr_data),
        .we          (we),
        .full        (full),
        .almost_full (almost_full),
        .rd_data     (rd_data),
        .re          (re),
        .not_empty   (not_empty),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_err     (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic w, input logic r, input logic c, input logic [7:0] d);
        we      = w;
        re      = r;
        clr_err = c;
        wr_data = d;
        @(posedge clk);
        #1;
        we      = 1'b0;
        re      = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic chk_state(input string tag, input int lvl, input int rd, input int ne,
                             input int ovf, input int unf);
        chk({tag, " level"}, int'(level), lvl);
        chk({tag, " rd_data"}, int'(rd_data), rd);
        chk({tag, " not_empty"}, int'(not_empty), ne);
        chk({tag, " overflow"}, int'(overflow), ovf);
        chk({tag, " underflow"}, int'(underflow), unf);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] b;
        int         lvl;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        we       = 1'b0;
        re       = 1'b0;
        clr_err  = 1'b0;
        wr_data  = 8'h00;

        // Empty-boundary, clear and single-entry replace vectors from reset.
        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00, 0, 0, 1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h5A, 1, 8'h5A, 1, 0, 1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 8'h5A, 1, 0, 0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h11, 1, 8'h11, 1, 0, 0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h22, 2, 8'h11, 1, 0, 0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 8'h22, 1, 0, 0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00, 0, 0, 0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_state("reset", 0, 0, 0, 0, 0);
        chk("reset full", int'(full), 0);
        chk("reset almost_full", int'(almost_full), 0);

        for (int i = 0; i < 7; i++) begin
            cyc(vecs[i].we, vecs[i].re, vecs[i].clr, vecs[i].wdata);
            chk_state($sformatf("vec%0d", i), vecs[i].exp_level, vecs[i].exp_rd,
                      vecs[i].exp_ne, vecs[i].exp_ovf, vecs[i].exp_unf);
        end

        // Fill 0x00..0x0F, watching the threshold and full boundaries.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(i));
            chk($sformatf("fill%0d level", i), int'(level), i + 1);
            chk($sformatf("fill%0d almost_full", i), int'(almost_full), (i + 1 >= 12) ? 1 : 0);
            chk($sformatf("fill%0d full", i), int'(full), (i + 1 == 16) ? 1 : 0);
            chk($sformatf("fill%0d rd_data", i), int'(rd_data), 0);
        end

        // Drain in order with no bubble.
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d rd_data", i), int'(rd_data), i);
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
        end
        chk_state("drained", 0, 0, 0, 0, 0);

        // Refill, then the full-boundary and flag-clear race.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(i));
        end
        chk("refill full", int'(full), 1);
        cyc(1'b1, 1'b0, 1'b0, 8'hAA);
        chk_state("reject AA", 16, 8'h00, 1, 1, 0);
        cyc(1'b1, 1'b1, 1'b0, 8'hBB);
        chk_state("full wr+rd BB", 16, 8'h01, 1, 1, 0);
        cyc(1'b1, 1'b0, 1'b1, 8'hCC);
        chk_state("clr race", 16, 8'h01, 1, 1, 0);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk_state("clr alone", 16, 8'h01, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drainBB%0d rd_data", i), int'(rd_data), (i == 15) ? 8'hBB : i + 1);
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
        end
        chk_state("drainedBB", 0, 0, 0, 0, 0);

        // Wrap: 13 writes, 27 write+read pairs at level 13, 13 reads.
        lvl = 0;
        for (int i = 0; i < 13; i++) begin
            b = 8'(i * 7 + 3);
            cyc(1'b1, 1'b0, 1'b0, b);
            q.push_back(b);
            lvl++;
            chk($sformatf("wrapA%0d level", i), int'(level), lvl);
            chk($sformatf("wrapA%0d almost_full", i), int'(almost_full), (lvl >= 12) ? 1 : 0);
        end
        for (int i = 13; i < 40; i++) begin
            chk($sformatf("wrapB%0d rd_data", i), int'(rd_data), int'(q[0]));
            b = 8'(i * 7 + 3);
            cyc(1'b1, 1'b1, 1'b0, b);
            void'(q.pop_front());
            q.push_back(b);
            chk($sformatf("wrapB%0d level", i), int'(level), 13);
        end
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("wrapC%0d rd_data", i), int'(rd_data), int'(q[0]));
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
            void'(q.pop_front());
            lvl--;
            chk($sformatf("wrapC%0d almost_full", i), int'(almost_full), (lvl >= 12) ? 1 : 0);
        end
        chk_state("wrap end", 0, 0, 0, 0, 0);

        // Reset mid-stream at level 7 with underflow set and we/re/clr_err active.
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        end
        chk_state("pre-reset", 7, 8'h40, 1, 0, 1);
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 8'h44);
        reset = 1'b0;
        chk_state("mid reset", 0, 0, 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 8'h33);
        chk_state("post reset 33", 1, 8'h33, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bridge_fifo
